// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage
// (master) and instruction memory (slave).
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) ();
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, variable-latency imem
// handshake with load-use stall, branch flush and abandoned-request draining.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PCWrite,
  input  logic                   IF_IDWrite,
  input  logic                   IF_ID_flush,
  input  logic [PC_WIDTH-1:0]    branch_target,
  fetch_stage_if.master          imem,
  output logic [PC_WIDTH-1:0]    IF_ID_pc4,
  output logic [INSTR_WIDTH-1:0] IF_ID_instr,
  output logic                   IF_ID_valid,
  output logic                   fetch_stall
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(4);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    w_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_buf_instr;
  logic [INSTR_WIDTH-1:0] w_buf_instr_nxt;
  logic [PC_WIDTH-1:0]    r_buf_pc4;
  logic [PC_WIDTH-1:0]    w_buf_pc4_nxt;
  logic [PC_WIDTH-1:0]    r_disc_addr;
  logic [PC_WIDTH-1:0]    w_disc_addr_nxt;

  logic [PC_WIDTH-1:0]    r_ifid_pc4_p1;
  logic [INSTR_WIDTH-1:0] r_ifid_instr_p1;
  logic                   r_vld_p1;
  logic [PC_WIDTH-1:0]    w_ifid_pc4_nxt;
  logic [INSTR_WIDTH-1:0] w_ifid_instr_nxt;
  logic                   w_vld_nxt;

  logic                   w_advance;
  logic                   w_ack;
  logic [PC_WIDTH-1:0]    w_pc_plus4;

  assign w_advance  = PCWrite & IF_IDWrite;
  assign w_ack      = imem.imem_ack;
  assign w_pc_plus4 = pc_inc(r_pc);

  // The holding buffer owns the fetched word while in HOLD, so no request is issued.
  assign imem.imem_req  = rst_n & (r_state != S_HOLD);
  assign imem.imem_addr = (r_state == S_DISCARD) ? r_disc_addr : r_pc;
  assign fetch_stall    = (r_state == S_DISCARD) | ((r_state == S_FETCH) & ~w_ack);

  assign IF_ID_pc4   = r_ifid_pc4_p1;
  assign IF_ID_instr = r_ifid_instr_p1;
  assign IF_ID_valid = r_vld_p1;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_buf_instr_nxt  = r_buf_instr;
    w_buf_pc4_nxt    = r_buf_pc4;
    w_disc_addr_nxt  = r_disc_addr;
    w_ifid_pc4_nxt   = r_ifid_pc4_p1;
    w_ifid_instr_nxt = r_ifid_instr_p1;
    w_vld_nxt        = r_vld_p1;

    if (IF_ID_flush) begin
      // A request already on the bus must finish at its original address,
      // so an un-acked FETCH is drained through DISCARD.
      w_pc_nxt         = branch_target;
      w_ifid_instr_nxt = '0;
      w_vld_nxt        = 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt     = S_DISCARD;
            w_disc_addr_nxt = r_pc;
          end
        end
        S_HOLD:    w_state_nxt = S_FETCH;
        S_DISCARD: w_state_nxt = w_ack ? S_FETCH : S_DISCARD;
        default:   w_state_nxt = S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            if (w_advance) begin
              w_ifid_pc4_nxt   = w_pc_plus4;
              w_ifid_instr_nxt = imem.imem_rdata;
              w_vld_nxt        = 1'b1;
              w_pc_nxt         = w_pc_plus4;
            end else begin
              w_buf_pc4_nxt   = w_pc_plus4;
              w_buf_instr_nxt = imem.imem_rdata;
              w_state_nxt     = S_HOLD;
            end
          end else if (IF_IDWrite) begin
            w_ifid_instr_nxt = '0;
            w_vld_nxt        = 1'b0;
          end
        end
        S_HOLD: begin
          if (w_advance) begin
            w_ifid_pc4_nxt   = r_buf_pc4;
            w_ifid_instr_nxt = r_buf_instr;
            w_vld_nxt        = 1'b1;
            w_pc_nxt         = w_pc_plus4;
            w_state_nxt      = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (w_ack) begin
            w_state_nxt = S_FETCH;
          end
          if (IF_IDWrite) begin
            w_ifid_instr_nxt = '0;
            w_vld_nxt        = 1'b0;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  // IF/ID stage boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_PC;
      r_ifid_pc4_p1   <= '0;
      r_ifid_instr_p1 <= '0;
      r_vld_p1        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_ifid_pc4_p1   <= w_ifid_pc4_nxt;
      r_ifid_instr_p1 <= w_ifid_instr_nxt;
      r_vld_p1        <= w_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_buf_instr <= w_buf_instr_nxt;
    r_buf_pc4   <= w_buf_pc4_nxt;
    r_disc_addr <= w_disc_addr_nxt;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the PC register and the IF/ID pipeline register, and is the consumer of the load-use stall signals `PCWrite` / `IF_IDWrite`. It also accepts the branch flush from ID and handles a req/ack instruction-memory handshake with variable latency. When memory is slow, it inserts bubbles and raises `fetch_stall`. It sits between instruction memory and the ID stage of the 5-stage MIPS pipeline.

## Interface
- `PC_WIDTH`, 32, PC and address width
- `INSTR_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `clk` in 1: single clock, all state updates on the rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `PCWrite` in 1: 1 = PC may advance (from hazard detection unit)
- `IF_IDWrite` in 1: 1 = IF/ID may load (from hazard detection unit)
- `IF_ID_flush` in 1: branch/jump taken in ID, redirect fetch
- `branch_target` in PC_WIDTH: redirect PC, valid with `IF_ID_flush`
- `imem_req` out 1: fetch request
- `imem_addr` out PC_WIDTH: fetch address, stable while `imem_req`=1 and no ack
- `imem_ack` in 1: read data valid this cycle; may be asserted in the same cycle as `imem_req`
- `imem_rdata` in INSTR_WIDTH: instruction, valid when `imem_ack`=1
- `IF_ID_pc4` out PC_WIDTH: registered PC+4 of the held instruction
- `IF_ID_instr` out INSTR_WIDTH: registered instruction (0 = NOP bubble)
- `IF_ID_valid` out 1: registered, 1 = real instruction
- `fetch_stall` out 1: no instruction delivered this cycle because of memory wait

## Operation
- `advance` = `PCWrite` & `IF_IDWrite`. A partial enable (only one of the two high) is treated as a stall.
- **Registers:**
  - `pc`
  - `state` ∈ {FETCH, HOLD, DISCARD}
  - `buf_instr`, `buf_pc4` (one-entry holding buffer)
  - `disc_addr` (address of an abandoned request)
  - IF/ID outputs
- **FETCH:**
  - `imem_req`=1, `imem_addr`=`pc`.
  - Ack and `advance`: IF/ID ← {`pc`+4, `imem_rdata`, valid=1}; `pc` ← `pc`+4; stay in FETCH.
  - Ack and not `advance`: buffer ← {`pc`+4, `imem_rdata`}; `pc` unchanged; go to HOLD; IF/ID unchanged.
  - No ack and `IF_IDWrite`=1: IF/ID ← bubble (instr=0, valid=0, pc4 unchanged); `fetch_stall`=1.
  - No ack and `IF_IDWrite`=0: IF/ID unchanged; `fetch_stall`=1.
- **HOLD:**
  - `imem_req`=0.
  - On `advance`: IF/ID ← buffer with valid=1; `pc` ← `pc`+4; go to FETCH.
  - Otherwise hold.
- **DISCARD:**
  - `imem_req`=1, `imem_addr`=`disc_addr`.
  - Ack data is dropped; on ack go to FETCH.
  - IF/ID ← bubble while `IF_IDWrite`=1; `fetch_stall`=1.
- **Flush (`IF_ID_flush`=1):** overrides `advance`, stall and ack handling in every state.
  - `pc` ← `branch_target`.
  - IF/ID ← bubble unconditionally, even if `IF_IDWrite`=0.
  - Buffer is invalidated.
  - FETCH without ack: `disc_addr` ← `pc`; next state DISCARD.
  - FETCH with ack, or HOLD: next state FETCH.
  - DISCARD without ack: stay in DISCARD (keep `disc_addr`).
  - DISCARD with ack: next state FETCH.
- **Width rules:**
  - PC+4 is computed modulo 2^PC_WIDTH; wrap from 32'hFFFF_FFFC gives 0.
  - `branch_target` is taken as-is; its low 2 bits are not checked.

## Timing
- **Reset:** while `rst_n`=0 at a rising edge:
  - `pc`=`RESET_PC`, `state`=FETCH.
  - `IF_ID_instr`=0, `IF_ID_valid`=0, `IF_ID_pc4`=0.
  - Buffer invalid.
  - `imem_req` is forced 0 combinationally whenever `rst_n`=0.
- **Reset mid-transaction:** any outstanding request is abandoned without DISCARD. The memory must tolerate `imem_req` dropping; the first request after reset uses `RESET_PC`.
- **Latency and throughput:**
  - Zero-wait memory: 1 instruction/cycle.
  - Instruction fetched at edge N (ack during cycle N-1) is visible on IF/ID outputs after edge N.
  - Each wait cycle produces exactly one bubble.
- `imem_req`, `imem_addr` and `fetch_stall` are combinational from `state`/`pc`/`imem_ack`. All IF/ID outputs are registered.
- **Handshake:** once `imem_req` rises, the request stays high with a constant `imem_addr` until `imem_ack`. Flush never changes the address of an outstanding request; DISCARD guarantees this.
- A HOLD exit and a new request happen on consecutive cycles: leaving HOLD at edge N puts the request for the new `pc` in cycle N.

## Test plan
- **Zero-wait streaming:** `RESET_PC`=0, ack tied 1, `advance`=1 for 4 cycles -> `IF_ID_pc4`=4,8,12,16, valid=1 each cycle, `fetch_stall`=0.
- **2-wait memory:** ack 2 cycles after each req -> IF/ID shows bubble, bubble, instr(0x0) with pc4=4; `fetch_stall`=1 during both wait cycles; `imem_addr` holds 0 throughout.
- **Load-use stall:** `PCWrite`=`IF_IDWrite`=0 in the ack cycle for addr 8 -> state HOLD, `imem_req`=0, IF/ID unchanged; release next cycle -> IF/ID = instr@8, pc4=12, next `imem_addr`=12.
- **Flush during wait:** req addr 0x20 pending, `IF_ID_flush`=1 with target 0x100 -> IF/ID bubble, `imem_addr` stays 0x20 until ack, that data is dropped, next request is 0x100.
- **Flush with simultaneous stall:** `IF_ID_flush`=1, `IF_IDWrite`=0, state HOLD -> IF/ID bubble, buffer discarded, next `imem_addr`=`branch_target`.
- **Sync reset mid-wait:** `rst_n`=0 for one cycle while a req at 0x40 is pending -> after that edge `pc`=`RESET_PC`, IF_ID_valid=0; `imem_req`=0 during the reset cycle.
